// File: rtl/synth_pkg.sv
// synth_pkg: shared synthesizer constants, including key/voice counts,
// the key index type and the per-key oscillator divisors.
package synth_pkg;
    localparam int NUM_KEYS   = 13;
    localparam int NUM_VOICES = 4;
    localparam int DIV_W      = 10;

    typedef logic [3:0] key_idx_t;

    // 12-TET divisors from low C (1000) to top C (500)
    localparam logic [DIV_W-1:0] NOTE_DIV [NUM_KEYS] = '{
        10'd1000, 10'd944, 10'd891, 10'd841, 10'd794, 10'd749, 10'd707,
        10'd667,  10'd630, 10'd595, 10'd561, 10'd530, 10'd500
    };
endpackage

// File: rtl/voice_allocator_if.sv
// voice_allocator_if: key bank in, per-voice oscillator controls out.
interface voice_allocator_if #(
    parameter int NUM_KEYS   = synth_pkg::NUM_KEYS,
    parameter int NUM_VOICES = synth_pkg::NUM_VOICES,
    parameter int DIV_W      = synth_pkg::DIV_W
);
    logic [NUM_KEYS-1:0]                keys;
    logic [NUM_VOICES-1:0]              voice_en;
    logic [NUM_VOICES-1:0]              voice_load;
    logic [NUM_VOICES-1:0][DIV_W-1:0]   voice_div;
    synth_pkg::key_idx_t [NUM_VOICES-1:0] voice_key;
    logic                               overflow;

    modport master (output keys, input voice_en, voice_load, voice_div, voice_key, overflow);
    modport slave  (input keys, output voice_en, voice_load, voice_div, voice_key, overflow);
endinterface

// File: rtl/voice_select.sv
// voice_select: finds the voice holding a key, the lowest free voice
// and the oldest active voice (ties to the lowest index).
module voice_select #(
    parameter int NUM_VOICES = synth_pkg::NUM_VOICES,
    parameter int VW         = 2
) (
    input  logic [NUM_VOICES-1:0]              voice_en_i,
    input  logic [NUM_VOICES-1:0][VW-1:0]      age_i,
    input  synth_pkg::key_idx_t [NUM_VOICES-1:0] voice_key_i,
    input  synth_pkg::key_idx_t                key_i,
    output logic [VW-1:0]                      hold_v_o,
    output logic                               hold_ok_o,
    output logic [VW-1:0]                      free_v_o,
    output logic                               free_ok_o,
    output logic [VW-1:0]                      old_v_o,
    output logic                               old_ok_o
);
    always_comb begin
        hold_v_o  = '0;
        hold_ok_o = 1'b0;
        free_v_o  = '0;
        free_ok_o = 1'b0;
        old_v_o   = '0;
        old_ok_o  = 1'b0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (voice_en_i[v] && voice_key_i[v] == key_i) begin
                hold_ok_o = 1'b1;
                hold_v_o  = VW'(v);
            end
            if (!voice_en_i[v]) begin
                free_ok_o = 1'b1;
                free_v_o  = VW'(v);
            end
        end
        for (int v = 0; v < NUM_VOICES; v++)
            if (voice_en_i[v] && (!old_ok_o || age_i[v] > age_i[old_v_o])) begin
                old_ok_o = 1'b1;
                old_v_o  = VW'(v);
            end
    end
endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: assigns pressed keys to oscillator voices, one key event per cycle.
// Define VOICE_STEAL_EN to steal the oldest voice when all are busy; otherwise the press is dropped.
module voice_allocator #(
    parameter int NUM_KEYS   = synth_pkg::NUM_KEYS,
    parameter int NUM_VOICES = synth_pkg::NUM_VOICES,
    parameter int DIV_W      = synth_pkg::DIV_W
) (
    input logic              clk,
    input logic              nRst,
    voice_allocator_if.slave bus
);
    import synth_pkg::*;

    localparam int VW = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;
`ifdef VOICE_STEAL_EN
    localparam bit STEAL = 1'b1;
`else
    localparam bit STEAL = 1'b0;
`endif

    logic [NUM_KEYS-1:0]              keys_q, pend_on_q, pend_on_d, pend_off_q, pend_off_d;
    logic [NUM_KEYS-1:0]              rise, fall, srv;
    logic [NUM_VOICES-1:0]            en_q, en_d, load_q, load_d;
    logic                             ovf_q, ovf_d;
    key_idx_t [NUM_VOICES-1:0]        key_q, key_d;
    logic [NUM_VOICES-1:0][DIV_W-1:0] div_q, div_d;
    logic [NUM_VOICES-1:0][VW-1:0]    age_q, age_d;
    logic                             is_off, is_on, upd;
    key_idx_t                         ev_key;
    logic [VW-1:0]                    hold_v, free_v, old_v, tgt, old_age;
    logic                             hold_ok, free_ok, old_ok;

    assign rise   = bus.keys & ~keys_q;
    assign fall   = ~bus.keys & keys_q;
    assign is_off = |pend_off_q;
    assign is_on  = ~is_off & (|pend_on_q);
    assign srv    = NUM_KEYS'(1) << ev_key;

    // Offs take priority over ons; lowest key index wins within a class
    always_comb begin
        ev_key = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--)
            if (is_off ? pend_off_q[k] : pend_on_q[k]) ev_key = key_idx_t'(k);
    end

    voice_select #(.NUM_VOICES(NUM_VOICES), .VW(VW)) u_sel (
        .voice_en_i (en_q),
        .age_i      (age_q),
        .voice_key_i(key_q),
        .key_i      (ev_key),
        .hold_v_o   (hold_v),
        .hold_ok_o  (hold_ok),
        .free_v_o   (free_v),
        .free_ok_o  (free_ok),
        .old_v_o    (old_v),
        .old_ok_o   (old_ok)
    );

    always_comb begin
        pend_on_d  = (pend_on_q & ~(is_on ? srv : '0) & ~fall) | rise;
        pend_off_d = (pend_off_q & ~(is_off ? srv : '0) & ~rise) | fall;
        en_d    = en_q;
        key_d   = key_q;
        div_d   = div_q;
        age_d   = age_q;
        load_d  = '0;
        ovf_d   = 1'b0;
        upd     = 1'b0;
        tgt     = hold_v;
        old_age = VW'(NUM_VOICES - 1);
        if (is_off && hold_ok) en_d[hold_v] = 1'b0;
        if (is_on) begin
            upd = 1'b1;
            if (hold_ok) old_age = age_q[hold_v];
            else if (free_ok) tgt = free_v;
            else begin
                ovf_d = 1'b1;
                upd   = STEAL && old_ok;
                tgt   = old_v;
            end
        end
        // Younger active voices age by one; the (re)assigned voice becomes the youngest
        if (upd) begin
            for (int v = 0; v < NUM_VOICES; v++)
                if (en_q[v] && age_q[v] < old_age) age_d[v] = age_q[v] + 1'b1;
            age_d[tgt]  = '0;
            en_d[tgt]   = 1'b1;
            key_d[tgt]  = ev_key;
            div_d[tgt]  = NOTE_DIV[ev_key];
            load_d[tgt] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            keys_q     <= '0;
            pend_on_q  <= '0;
            pend_off_q <= '0;
            en_q       <= '0;
            load_q     <= '0;
            ovf_q      <= 1'b0;
            key_q      <= '0;
            div_q      <= '0;
            age_q      <= '0;
        end else begin
            keys_q     <= bus.keys;
            pend_on_q  <= pend_on_d;
            pend_off_q <= pend_off_d;
            en_q       <= en_d;
            load_q     <= load_d;
            ovf_q      <= ovf_d;
            key_q      <= key_d;
            div_q      <= div_d;
            age_q      <= age_d;
        end
    end

    assign bus.voice_en   = en_q;
    assign bus.voice_load = load_q;
    assign bus.overflow   = ovf_q;
    assign bus.voice_key  = key_q;
    assign bus.voice_div  = div_q;
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed key sequences; expected load/overflow events are queued
// by the stimulus and checked by a monitor whenever the DUT pulses.
module tb_voice_allocator;
    logic clk = 1'b0;
    logic nRst;
    always #5 clk = ~clk;

    voice_allocator_if bus ();
    voice_allocator dut (.clk(clk), .nRst(nRst), .bus(bus));

    typedef struct packed {
        logic [3:0]  load;
        logic        ovf;
        logic [3:0]  en;
        logic [15:0] keys;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    int   divs [13] = '{1000, 944, 891, 841, 794, 749, 707, 667, 630, 595, 561, 530, 500};

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(logic [3:0] l, logic o, logic [3:0] en, logic [15:0] k);
        sb.push_back(exp_t'{l, o, en, k});
    endtask

    always @(negedge clk) begin
        if (nRst && (|bus.voice_load || bus.overflow)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got load=%b ovf=%b expected no pulse",
                         bus.voice_load, bus.overflow);
            end else begin
                cur = sb.pop_front();
                chk("ev_load", 64'(bus.voice_load), 64'(cur.load));
                chk("ev_ovf", 64'(bus.overflow), 64'(cur.ovf));
                chk("ev_en", 64'(bus.voice_en), 64'(cur.en));
                chk("ev_key", 64'(bus.voice_key), 64'(cur.keys));
                for (int v = 0; v < 4; v++)
                    if (cur.load[v]) chk("ev_div", 64'(bus.voice_div[v]), 64'(divs[cur.keys[v*4 +: 4]]));
            end
        end
    end

    initial begin
        nRst = 1'b0;
        bus.keys = 13'h1FFF;
        cyc(3);
        @(negedge clk);
        chk("rst_en", 64'(bus.voice_en), 64'h0);
        chk("rst_load", 64'(bus.voice_load), 64'h0);
        chk("rst_ovf", 64'(bus.overflow), 64'h0);
        chk("rst_key", 64'(bus.voice_key), 64'h0);
        chk("rst_div", 64'(bus.voice_div), 64'h0);

        // Keys 0-3 fill voices 0-3 on consecutive cycles
        @(posedge clk);
        #1;
        bus.keys = 13'h000F;
        nRst = 1'b1;
        push(4'b0001, 1'b0, 4'b0001, 16'h0000);
        push(4'b0010, 1'b0, 4'b0011, 16'h0010);
        push(4'b0100, 1'b0, 4'b0111, 16'h0210);
        push(4'b1000, 1'b0, 4'b1111, 16'h3210);
        cyc(8);
        chk("fill_en", 64'(bus.voice_en), 64'hF);

        // Release key 1 and press key 9 together: key 9 reuses voice 1
        bus.keys = 13'h020D;
        push(4'b0010, 1'b0, 4'b1111, 16'h3290);
        cyc(6);
        chk("swap_en", 64'(bus.voice_en), 64'hF);

        // Key 7 with all voices busy; voice 0 is the oldest
        bus.keys = 13'h028D;
`ifdef VOICE_STEAL_EN
        push(4'b0001, 1'b1, 4'b1111, 16'h3297);
`else
        push(4'b0000, 1'b1, 4'b1111, 16'h3290);
`endif
        cyc(5);
        chk("ovf_en", 64'(bus.voice_en), 64'hF);

        bus.keys = 13'h0000;
        cyc(8);
        chk("rel_all_en", 64'(bus.voice_en), 64'h0);

        // Single press latency, then release latency
        bus.keys = 13'h0010;
        push(4'b0001, 1'b0, 4'b0001, 16'h3294);
        @(negedge clk);
        @(negedge clk);
        chk("lat_e", 64'(bus.voice_en), 64'h0);
        @(negedge clk);
        chk("lat_e1", 64'(bus.voice_en), 64'h1);
        @(posedge clk);
        #1;
        bus.keys = 13'h0000;
        @(negedge clk);
        @(negedge clk);
        chk("off_e", 64'(bus.voice_en), 64'h1);
        @(negedge clk);
        chk("off_e1", 64'(bus.voice_en), 64'h0);
        cyc(2);

        // Key 5 pressed for one cycle during a backlog is never allocated
        bus.keys = 13'h0007;
        push(4'b0001, 1'b0, 4'b0001, 16'h3290);
        push(4'b0010, 1'b0, 4'b0011, 16'h3210);
        push(4'b0100, 1'b0, 4'b0111, 16'h3210);
        cyc(1);
        bus.keys = 13'h0027;
        cyc(1);
        bus.keys = 13'h0007;
        cyc(8);
        chk("glitch_en", 64'(bus.voice_en), 64'h7);

        bus.keys = 13'h0003;
        cyc(4);
        chk("two_en", 64'(bus.voice_en), 64'h3);

        // Reset while key 6 is pending; held keys reallocate from voice 0
        bus.keys = 13'h0043;
        cyc(1);
        nRst = 1'b0;
        @(negedge clk);
        chk("mid_rst_en", 64'(bus.voice_en), 64'h0);
        chk("mid_rst_key", 64'(bus.voice_key), 64'h0);
        chk("mid_rst_div", 64'(bus.voice_div), 64'h0);
        push(4'b0001, 1'b0, 4'b0001, 16'h0000);
        push(4'b0010, 1'b0, 4'b0011, 16'h0010);
        push(4'b0100, 1'b0, 4'b0111, 16'h0610);
        @(posedge clk);
        #1;
        nRst = 1'b1;
        cyc(6);
        chk("realloc_en", 64'(bus.voice_en), 64'h7);

        // Release then re-press key 1 before its off is served: retrigger, never freed
        bus.keys = 13'h0040;
        cyc(1);
        bus.keys = 13'h0042;
        push(4'b0010, 1'b0, 4'b0110, 16'h0610);
        cyc(6);
        chk("retrig_en", 64'(bus.voice_en), 64'h6);

        chk("sb_empty", 64'(sb.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/voice_allocator.md
# voice_allocator

- Polyphony controller for the synthesizer.
- Watches the key bank and assigns each pressed key to one of `NUM_VOICES` oscillator instances.
- Drives each oscillator's enable, phase-restart pulse and note divisor.
- Sits between the key input synchronizers and the oscillator bank.
- When all voices are busy, either steals the oldest voice or drops the press, depending on configuration.

## Interface
Parameters:
- `NUM_KEYS`, 13: number of key inputs (one octave plus top C).
- `NUM_VOICES`, 4: number of oscillator voices managed.
- `DIV_W`, 10: divisor width driven to each oscillator.

Ports:
- `clk` input 1: system clock.
- `nRst` input 1: asynchronous, active-low reset.
- `keys` input `NUM_KEYS`: synchronized key levels, 1 = pressed.
- `voice_en` output `NUM_VOICES`: voice active; gates the oscillator enable.
- `voice_load` output `NUM_VOICES`: one-cycle pulse on (re)assignment; the oscillator restarts its phase.
- `voice_div` output `NUM_VOICES` x `DIV_W`: divisor for each voice, taken from `NOTE_DIV[key]`.
- `voice_key` output `NUM_VOICES` x 4: key index held by each voice.
- `overflow` output 1: one-cycle pulse when a key-on found no free voice.

## Operation
Edge detection:
- `keys_q` registers `keys`.
- A rising edge (`keys & ~keys_q`) sets `pend_on[k]` and clears `pend_off[k]`.
- A falling edge sets `pend_off[k]` and clears `pend_on[k]`.

Event processing, at most one event per cycle:
- All pending key-offs are served before any key-on.
- Within each class, the lowest key index goes first.
- The served pending bit clears in the same cycle.

Key-off k:
- If voice v holds k: `voice_en[v]`←0. `voice_key` and `voice_div` hold their last values.
- If no voice holds k: no action.

Key-on k:
- **Key already held by voice v:** retrigger. `voice_load[v]` pulses and the voice's age resets.
- **A free voice exists:** take the lowest-index free voice v. Set `voice_en[v]`←1, `voice_key[v]`←k, `voice_div[v]`←`NOTE_DIV[k]`, and pulse `voice_load[v]`.
- **No free voice:** pulse `overflow`, then resolve per Configuration.

Age tracking:
- Each active voice has a rank, 0 to `NUM_VOICES`-1.
- On allocation or retrigger of v: age[v]←0, and every other active voice with age < old age[v] increments.
- A freshly allocated voice counts as old age = `NUM_VOICES`-1.
- Oldest voice = maximum age among active voices; ties go to the lowest index.
- Freed voices keep a stale age, which is ignored.

FSM: none beyond the pending masks. The block is always ready, so there is no back-pressure to the keys.

## Timing
- Reset values: `voice_en`=0, `voice_load`=0, `voice_div`=0, `voice_key`=0, `overflow`=0, `keys_q`=0, pending masks 0, ages 0.
- Latency for an isolated key change: `keys` changes before edge E; the pending bit is set at E; outputs update at E+1; `voice_load` is high from E+1 to E+2.
- Burst: n simultaneous changes are served over n consecutive cycles. Offs go first, so a release and a press in the same cycle let the press reuse the released voice.
- Press then release before service: `pend_on` is cleared, and no voice is ever allocated.
- Release then re-press before the off is served: `pend_off` is cleared and `pend_on` is set. The held voice retriggers and is never freed.
- `nRst` asserted mid-operation clears everything immediately. Keys still held at reset release are seen as rising edges (`keys_q`=0) and are re-allocated.
- `voice_load` and `overflow` are never high for two consecutive cycles for the same event.

## Configuration
Macro `VOICE_STEAL_EN`:
- **Defined:** on overflow, the oldest voice v is reassigned to k. Its fields update and `voice_load[v]` pulses in the same cycle as `overflow`.
- **Undefined:** the press is discarded. The key stays unsounded until re-pressed; `overflow` still pulses.

## Structure
- Package `synth_pkg` holds:
  - the `NOTE_DIV` constant array (`NUM_KEYS` entries of `DIV_W` bits, the 12-TET divisor per key at the system clock);
  - the key index typedef `key_idx_t` (4 bits);
  - the default `NUM_VOICES`.
- Sub-module `voice_select`: combinational. Inputs are `voice_en`, ages and the target key. Outputs are the holding voice (if any), the lowest free voice and the oldest voice, each with a valid flag.
- The top level holds the edge detection, pending masks, age registers and output registers.

## Test plan
- **Reset:** `nRst` low with keys=0x1FFF → all outputs 0; after release, keys 0–3 occupy voices 0–3 on four consecutive cycles, each `voice_load` pulsing once.
- **Single press:** key 4 → at E+1, `voice_en`=0001, `voice_key[0]`=4, `voice_div[0]`=`NOTE_DIV[4]`; release → `voice_en`=0000 two cycles after the fall.
- **Overflow:**
  - Setup: keys 0, 1, 2, 3 pressed in order, then key 7.
  - With `VOICE_STEAL_EN`: voice 0 becomes key 7, `overflow` and `voice_load[0]` pulse.
  - Without it: `voice_key` is unchanged and only `overflow` pulses.
- **Same-cycle release and press:** voices 0–3 full; key 1 released and key 9 pressed in the same cycle → key 1's voice frees first, key 9 takes voice 1, no `overflow`.
- **Glitch:** key 5 pressed for one cycle during a 3-event backlog → no allocation for key 5, `voice_en` unaffected.
- **Mid-operation reset:** `nRst` pulsed low while 2 voices are active and 1 event is pending → everything clears; the keys still held are reallocated from voice 0 upward after release.
